// File: rtl/change_return_if.sv
// Handshake bundle between the change-return sequencer and its neighbours.
// Sequencer takes the slave view; the amount source / dispenser side takes master.
// All sequencer outputs are registered; the dispenser stalls a coin by holding coin_ack low.
interface change_return_if #(
  parameter int MONEY_W = 12
);
  logic               start;
  logic [MONEY_W-1:0] amount;
  logic               tick;
  logic               coin_ack;
  logic               coin_valid;
  logic [1:0]         coin_type;
  logic [MONEY_W-1:0] remaining;
  logic               busy;
  logic               done;
  logic               err;
  logic [3:0]         coin_count;

  modport slave (
    input  start, amount, tick, coin_ack,
    output coin_valid, coin_type, remaining, busy, done, err, coin_count
  );

  modport master (
    output start, amount, tick, coin_ack,
    input  coin_valid, coin_type, remaining, busy, done, err, coin_count
  );
endinterface

// File: rtl/change_return_sequencer.sv
// Pays out a change amount as a tick-paced sequence of coins, largest first (50, 10, 5).
// Latency: status one cycle after start; a coin is presented one cycle after each accepted tick.
// Backpressure: coin held stable until coin_ack; ticks arriving while a coin is pending are dropped.
module change_return_sequencer #(
  parameter int MONEY_W   = 12,
  parameter int MAX_MONEY = 100
) (
  input logic            clk,
  input logic            rst,
  change_return_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TICK,
    WAIT_ACK,
    FINISH
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_50   = 2'b11;

  localparam logic [MONEY_W-1:0] VAL_5   = MONEY_W'(5);
  localparam logic [MONEY_W-1:0] VAL_10  = MONEY_W'(10);
  localparam logic [MONEY_W-1:0] VAL_50  = MONEY_W'(50);
  localparam logic [MONEY_W-1:0] MAX_AMT = MONEY_W'(MAX_MONEY);

  state_t             state_q, state_d;
  logic               coin_valid_q, coin_valid_d;
  logic [1:0]         coin_type_q, coin_type_d;
  logic [MONEY_W-1:0] remaining_q, remaining_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [3:0]         coin_count_q, coin_count_d;

  logic               amount_bad;
  logic [1:0]         coin_sel;
  logic [MONEY_W-1:0] coin_val;
  logic [MONEY_W-1:0] remaining_after;

  // Start amounts above the ceiling or not a multiple of the smallest coin are rejected.
  always_comb begin
    amount_bad = (bus.amount > MAX_AMT) || ((bus.amount % VAL_5) != '0);
  end

  // Greedy pick for the next coin; never exceeds the balance because the balance is a multiple of 5.
  always_comb begin
    coin_sel = COIN_5;
    if (remaining_q >= VAL_50) begin
      coin_sel = COIN_50;
    end else if (remaining_q >= VAL_10) begin
      coin_sel = COIN_10;
    end
  end

  // Face value of the coin currently presented to the dispenser.
  always_comb begin
    coin_val = VAL_5;
    case (coin_type_q)
      COIN_50: coin_val = VAL_50;
      COIN_10: coin_val = VAL_10;
      default: coin_val = VAL_5;
    endcase
    remaining_after = remaining_q - coin_val;
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d      = state_q;
    coin_valid_d = coin_valid_q;
    coin_type_d  = coin_type_q;
    remaining_d  = remaining_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    coin_count_d = coin_count_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        // A tick in the same cycle as start is deliberately ignored.
        if (bus.start) begin
          if (amount_bad) begin
            err_d = 1'b1;
          end else if (bus.amount == '0) begin
            state_d      = FINISH;
            done_d       = 1'b1;
            coin_count_d = 4'd0;
            remaining_d  = '0;
          end else begin
            state_d      = WAIT_TICK;
            remaining_d  = bus.amount;
            coin_count_d = 4'd0;
            busy_d       = 1'b1;
          end
        end
      end

      WAIT_TICK: begin
        if (bus.tick) begin
          state_d      = WAIT_ACK;
          coin_valid_d = 1'b1;
          coin_type_d  = coin_sel;
        end
      end

      WAIT_ACK: begin
        // coin_valid is always high in this state, so ack alone completes the transfer.
        if (bus.coin_ack) begin
          coin_valid_d = 1'b0;
          coin_type_d  = COIN_NONE;
          remaining_d  = remaining_after;
          if (coin_count_q != 4'hF) begin
            coin_count_d = coin_count_q + 4'd1;
          end
          if (remaining_after == '0) begin
            state_d = FINISH;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = WAIT_TICK;
          end
        end
      end

      FINISH: begin
        // done was raised on entry; it drops as we return to IDLE.
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d      = IDLE;
        coin_valid_d = 1'b0;
        coin_type_d  = COIN_NONE;
        busy_d       = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight coin without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      coin_valid_q <= 1'b0;
      coin_type_q  <= COIN_NONE;
      remaining_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      coin_count_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      coin_valid_q <= coin_valid_d;
      coin_type_q  <= coin_type_d;
      remaining_q  <= remaining_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      coin_count_q <= coin_count_d;
    end
  end

  assign bus.coin_valid = coin_valid_q;
  assign bus.coin_type  = coin_type_q;
  assign bus.remaining  = remaining_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.coin_count = coin_count_q;

endmodule

// File: tb/tb_change_return_sequencer.sv
// Scoreboard bench for change_return_sequencer.
// Expected coins, done counts and err events are queued at stimulus time and popped as the DUT emits them.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge or just after the rising edge.
module tb_change_return_sequencer;

  localparam int MONEY_W = 12;

  logic clk = 1'b0;
  logic rst;

  change_return_if #(.MONEY_W(MONEY_W)) bus ();

  change_return_sequencer #(.MONEY_W(MONEY_W), .MAX_MONEY(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [1:0] exp_coin_q[$];
  int         exp_done_q[$];
  int         exp_err_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Greedy reference model of one complete payout.
  task automatic push_payout(input int amt);
    int rem;
    int n;
    rem = amt;
    n   = 0;
    while (rem > 0) begin
      if (rem >= 50) begin
        exp_coin_q.push_back(2'b11);
        rem -= 50;
      end else if (rem >= 10) begin
        exp_coin_q.push_back(2'b10);
        rem -= 10;
      end else begin
        exp_coin_q.push_back(2'b01);
        rem -= 5;
      end
      n++;
    end
    exp_done_q.push_back((n > 15) ? 15 : n);
  endtask

  // Per-cycle scoreboard, evaluated on the falling edge.
  task automatic monitor();
    if (bus.coin_valid && bus.coin_ack) begin
      if (exp_coin_q.size() == 0) check_eq("unexpected_coin", 1, 0);
      else check_eq("coin_type", 32'(bus.coin_type), 32'(exp_coin_q.pop_front()));
    end
    if (!bus.coin_valid) check_eq("type_when_invalid", 32'(bus.coin_type), 0);
    if (bus.done) begin
      if (exp_done_q.size() == 0) check_eq("unexpected_done", 1, 0);
      else begin
        check_eq("done_count", 32'(bus.coin_count), 32'(exp_done_q.pop_front()));
        check_eq("done_remaining", 32'(bus.remaining), 0);
        check_eq("done_busy", 32'(bus.busy), 0);
      end
    end
    if (bus.err) begin
      if (exp_err_q.size() == 0) check_eq("unexpected_err", 1, 0);
      else check_eq("err_remaining", 32'(bus.remaining), 32'(exp_err_q.pop_front()));
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  // Wait for the next tick gap, pulse tick, then ack the coin one cycle after it appears.
  task automatic pay_one(input int gap);
    int n;
    repeat (gap) step();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    n = 0;
    while (!bus.coin_valid && n < 10) begin
      step();
      n++;
    end
    if (!bus.coin_valid) check_eq("valid_timeout", 0, 1);
    step();
    bus.coin_ack = 1'b1;
    step();
    bus.coin_ack = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, 32'(bus.coin_valid), 0);
    check_eq({tag, "_type"}, 32'(bus.coin_type), 0);
    check_eq({tag, "_remaining"}, 32'(bus.remaining), 0);
    check_eq({tag, "_busy"}, 32'(bus.busy), 0);
    check_eq({tag, "_done"}, 32'(bus.done), 0);
    check_eq({tag, "_err"}, 32'(bus.err), 0);
    check_eq({tag, "_count"}, 32'(bus.coin_count), 0);
  endtask

  initial begin
    int   exp_rem[5];
    logic stable;
    logic quiet;

    exp_rem = '{35, 25, 15, 5, 0};
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.amount   = '0;
    bus.tick     = 1'b0;
    bus.coin_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // 85 -> 50,10,10,10,5 with ticks every 20 cycles
    push_payout(85);
    bus.amount = 12'd85;
    bus.start  = 1'b1;
    step();
    bus.start = 1'b0;
    check_eq("t1_busy", 32'(bus.busy), 1);
    check_eq("t1_remaining_latched", 32'(bus.remaining), 85);
    for (int i = 0; i < 5; i++) begin
      pay_one(19);
      check_eq("t1_remaining", 32'(bus.remaining), 32'(exp_rem[i]));
    end
    check_eq("t1_done", 32'(bus.done), 1);
    step();
    check_eq("t1_done_single", 32'(bus.done), 0);
    check_eq("t1_busy_after", 32'(bus.busy), 0);
    check_eq("t1_count", 32'(bus.coin_count), 5);

    // zero amount finishes immediately
    exp_done_q.push_back(0);
    bus.amount = 12'd0;
    bus.start  = 1'b1;
    step();
    bus.start = 1'b0;
    check_eq("t2_done", 32'(bus.done), 1);
    check_eq("t2_busy", 32'(bus.busy), 0);
    check_eq("t2_valid", 32'(bus.coin_valid), 0);
    check_eq("t2_err", 32'(bus.err), 0);
    step();
    check_eq("t2_done_single", 32'(bus.done), 0);

    // illegal amounts: not a multiple of 5, and above the ceiling
    exp_err_q.push_back(0);
    bus.amount = 12'd37;
    bus.start  = 1'b1;
    step();
    bus.start = 1'b0;
    check_eq("t3_err37", 32'(bus.err), 1);
    step();
    check_eq("t3_err_single", 32'(bus.err), 0);
    exp_err_q.push_back(0);
    bus.amount = 12'd105;
    bus.start  = 1'b1;
    step();
    bus.start = 1'b0;
    check_eq("t3_err105", 32'(bus.err), 1);
    check_eq("t3_busy", 32'(bus.busy), 0);
    check_eq("t3_remaining", 32'(bus.remaining), 0);
    step();
    check_eq("t3_valid", 32'(bus.coin_valid), 0);

    // 60 with a long ack stall: coin held, ticks and start dropped
    push_payout(60);
    bus.amount = 12'd60;
    bus.start  = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (5) step();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    check_eq("t4_valid", 32'(bus.coin_valid), 1);
    check_eq("t4_type", 32'(bus.coin_type), 3);
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (i % 15 == 5) bus.tick = 1'b1;
      if (i == 20) begin
        bus.amount = 12'd5;
        bus.start  = 1'b1;
      end
      step();
      bus.tick  = 1'b0;
      bus.start = 1'b0;
      if (!(bus.coin_valid && bus.coin_type == 2'b11 && bus.busy)) stable = 1'b0;
    end
    check_eq("t4_hold_stable", 32'(stable), 1);
    bus.coin_ack = 1'b1;
    step();
    bus.coin_ack = 1'b0;
    check_eq("t4_remaining", 32'(bus.remaining), 10);
    check_eq("t4_valid_low", 32'(bus.coin_valid), 0);
    quiet = 1'b1;
    repeat (10) begin
      step();
      if (bus.coin_valid) quiet = 1'b0;
    end
    check_eq("t4_ticks_dropped", 32'(quiet), 1);
    pay_one(3);
    step();
    check_eq("t4_count", 32'(bus.coin_count), 2);

    // 100 interrupted by async reset during the second coin
    exp_coin_q.push_back(2'b11);
    bus.amount = 12'd100;
    bus.start  = 1'b1;
    step();
    bus.start = 1'b0;
    pay_one(4);
    check_eq("t5_remaining", 32'(bus.remaining), 50);
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    check_eq("t5_second_valid", 32'(bus.coin_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("t5_async_rst");
    step();
    rst = 1'b0;
    step();
    push_payout(15);
    bus.amount = 12'd15;
    bus.start  = 1'b1;
    step();
    bus.start = 1'b0;
    pay_one(4);
    pay_one(4);
    step();
    check_eq("t5_count", 32'(bus.coin_count), 2);
    check_eq("t5_busy", 32'(bus.busy), 0);

    // tick coinciding with start is ignored
    push_payout(5);
    bus.amount = 12'd5;
    bus.start  = 1'b1;
    bus.tick   = 1'b1;
    step();
    bus.start = 1'b0;
    bus.tick  = 1'b0;
    check_eq("t6_busy", 32'(bus.busy), 1);
    quiet = 1'b1;
    repeat (10) begin
      step();
      if (bus.coin_valid) quiet = 1'b0;
    end
    check_eq("t6_no_early_coin", 32'(quiet), 1);
    pay_one(2);
    step();
    check_eq("t6_count", 32'(bus.coin_count), 1);
    repeat (3) step();

    check_eq("coin_queue_empty", 32'(exp_coin_q.size()), 0);
    check_eq("done_queue_empty", 32'(exp_done_q.size()), 0);
    check_eq("err_queue_empty", 32'(exp_err_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
